// File: rtl/pmp_pkg.sv
// ============================================================================
// pmp_pkg : opcodes, control-word fields and FSM encoding for the PMP channel
// Rev 1.0
// ============================================================================
`default_nettype none

package pmp_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_MATCH = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 14;
  localparam int LEN_HI = 13;
  localparam int LEN_LO = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } pmp_state_t;

endpackage

`default_nettype wire

// File: rtl/pmm_window_cmp.sv
// ============================================================================
// pmm_window_cmp : byte shift window, fill counter and length-masked comparator
// Rev 1.0
// ============================================================================
`default_nettype none

module pmm_window_cmp #(
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = $clog2(PAT_MAX + 1),
  parameter int IDX_W   = $clog2(PAT_MAX)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic                   clr,
  input  logic [7:0]             byte_in,
  input  logic [8*PAT_MAX-1:0]   pattern,
  input  logic [LEN_W-1:0]       pat_len,
  output logic                   hit
);

  logic [PAT_MAX-1:0][7:0] r_window;
  logic [PAT_MAX-1:0][7:0] w_pat;
  logic [LEN_W-1:0]        r_fill;
  logic                    r_shifted;
  logic [PAT_MAX-1:0]      w_byte_ok;

  assign w_pat = pattern;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      r_window  <= '0;
      r_fill    <= '0;
      r_shifted <= 1'b0;
    end else begin
      r_shifted <= shift_en;
      if (shift_en) begin
        r_window <= {r_window[PAT_MAX-2:0], byte_in};
        if (r_fill != LEN_W'(PAT_MAX)) begin
          r_fill <= r_fill + LEN_W'(1);
        end
      end
    end
  end

  // Window byte i (i bytes old) lines up with pattern byte pat_len-1-i.
  for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_cmp
    logic [LEN_W-1:0] w_src;
    assign w_src         = pat_len - LEN_W'(gi) - LEN_W'(1);
    assign w_byte_ok[gi] = (LEN_W'(gi) >= pat_len) ||
                           (r_window[gi] == w_pat[w_src[IDX_W-1:0]]);
  end

  assign hit = r_shifted && (pat_len != '0) && (r_fill >= pat_len) && (&w_byte_ok);

endmodule

`default_nettype wire

// File: rtl/pmm_unit.sv
// ============================================================================
// pmm_unit : per-module command receiver; loads a byte pattern or scans data
//            against it one byte per cycle, with sticky flag and match count
// Rev 1.0
// ============================================================================
`default_nettype none

module pmm_unit #(
  parameter int DATA_W  = 64,
  parameter int CTRL_W  = 16,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic [CTRL_W-1:0] control,
  input  logic              data_ready,
  output logic              data_accepted,
  output logic              pattern_accepted,
  output logic [CNT_W-1:0]  match_count
);

  import pmp_pkg::*;

  localparam int LEN_W = $clog2(PAT_MAX + 1);
  localparam int IDX_W = $clog2(PAT_MAX);

  pmp_state_t         r_state;
  pmp_state_t         w_state_nxt;
  logic [DATA_W-1:0]  r_data;
  logic [LEN_W-1:0]   r_nbytes;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_pattern;
  logic [LEN_W-1:0]   r_pat_len;
  logic               r_pat_valid;
  logic               r_accepted;
  logic               r_pat_acc;
  logic [CNT_W-1:0]   r_count;

  logic               w_capture;
  logic [1:0]         w_op;
  logic               w_shift;
  logic               w_clr;
  logic               w_acc_nxt;
  logic               w_hit;
  logic [7:0]         w_byte;
  logic [DATA_W-1:0]  w_load_pat;
  logic               w_unused_ctrl;

  assign w_op          = control[OP_HI:OP_LO];
  assign w_capture     = (r_state == ST_IDLE) && data_ready && !r_accepted;
  assign w_byte        = r_data[8*r_idx +: 8];
  assign w_unused_ctrl = ^control[LEN_LO-1:0];

  for (genvar gk = 0; gk < PAT_MAX; gk++) begin : g_pat_mask
    assign w_load_pat[8*gk +: 8] = (LEN_W'(gk) < r_nbytes) ? r_data[8*gk +: 8] : 8'h00;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_clr       = 1'b0;
    w_acc_nxt   = r_accepted;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          case (w_op)
            OP_LOAD:  w_state_nxt = ST_LOAD;
            OP_MATCH: w_state_nxt = ST_SCAN;
            OP_CLEAR: begin
              w_state_nxt = ST_DONE;
              w_clr       = 1'b1;
            end
            default:  w_state_nxt = ST_DONE;
          endcase
        end
      end
      ST_LOAD: begin
        w_clr       = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_SCAN: begin
        w_shift = 1'b1;
        if (LEN_W'(r_idx) == r_nbytes - LEN_W'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // First DONE cycle always raises the handshake so a dropped
        // data_ready still sees exactly one pulse.
        if (!r_accepted) begin
          w_acc_nxt = 1'b1;
        end else if (!data_ready) begin
          w_acc_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_nbytes    <= '0;
      r_idx       <= '0;
      r_pattern   <= '0;
      r_pat_len   <= '0;
      r_pat_valid <= 1'b0;
      r_accepted  <= 1'b0;
      r_pat_acc   <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_accepted <= w_acc_nxt;
      if (w_capture) begin
        r_data   <= data;
        r_nbytes <= LEN_W'(control[LEN_HI:LEN_LO]) + LEN_W'(1);
        r_idx    <= '0;
      end
      if (w_shift) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (r_state == ST_LOAD) begin
        r_pattern   <= w_load_pat;
        r_pat_len   <= r_nbytes;
        r_pat_valid <= 1'b1;
      end
      if (w_clr) begin
        r_pat_acc <= 1'b0;
        r_count   <= '0;
      end else if (w_hit && r_pat_valid) begin
        r_pat_acc <= 1'b1;
        if (r_count != {CNT_W{1'b1}}) begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  pmm_window_cmp #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W),
    .IDX_W   (IDX_W)
  ) u_window (
    .clk      (clk),
    .reset    (reset),
    .shift_en (w_shift),
    .clr      (w_clr),
    .byte_in  (w_byte),
    .pattern  (r_pattern),
    .pat_len  (r_pat_len),
    .hit      (w_hit)
  );

  assign data_accepted    = r_accepted;
  assign pattern_accepted = r_pat_acc;
  assign match_count      = r_count;

endmodule

`default_nettype wire
